// File: rtl/pwm_gate_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pwm_gate_gen
// Purpose  : Counter-based PWM generator with complementary, dead-time
//            separated gate drive for a buck power stage. Period, duty and
//            dead time arrive on a valid/ready port, are held in a pending
//            set and copied to the active set only at a period boundary.
// Ports    : clk          - rising-edge clock
//            rst          - asynchronous reset, active low
//            en           - run enable; low forces both gates off, cnt = 0
//            cfg_valid    - configuration offer
//            cfg_ready    - pending slot free (= !pend)
//            cfg_period   - requested period in cycles (< 2 is rejected)
//            cfg_duty     - requested high-side on-count
//            cfg_dead     - requested dead time in cycles
//            cfg_err      - one-cycle pulse for a rejected transfer
//            gate         - high-side drive (registered)
//            gate_lo      - low-side drive (registered)
//            period_start - one-cycle pulse, one cycle after cnt == 0
// Revision : 1.0 - initial release
// ============================================================================
module pwm_gate_gen #(
    parameter int CNT_WIDTH  = 16,
    parameter int DEAD_WIDTH = 8,
    parameter int DEF_PERIOD = 200,
    parameter int DEF_DUTY   = 100,
    parameter int DEF_DEAD   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CNT_WIDTH-1:0]  cfg_period,
    input  logic [CNT_WIDTH-1:0]  cfg_duty,
    input  logic [DEAD_WIDTH-1:0] cfg_dead,
    output logic                  cfg_err,
    output logic                  gate,
    output logic                  gate_lo,
    output logic                  period_start
);

    localparam logic [CNT_WIDTH-1:0]  c_def_period = CNT_WIDTH'(DEF_PERIOD);
    localparam logic [CNT_WIDTH-1:0]  c_def_duty   = CNT_WIDTH'(DEF_DUTY);
    localparam logic [DEAD_WIDTH-1:0] c_def_dead   = DEAD_WIDTH'(DEF_DEAD);
    localparam logic [CNT_WIDTH-1:0]  c_cnt_one    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  c_min_period = CNT_WIDTH'(2);
    localparam logic [DEAD_WIDTH-1:0] c_dead_one   = DEAD_WIDTH'(1);

    typedef enum logic [1:0] {
        c_st_off  = 2'd0,
        c_st_dead = 2'd1,
        c_st_hi   = 2'd2,
        c_st_lo   = 2'd3
    } state_t;

    // Active and pending configuration
    logic [CNT_WIDTH-1:0]  r_per_a, r_duty_a, r_per_p, r_duty_p;
    logic [DEAD_WIDTH-1:0] r_dead_a, r_dead_p;
    logic                  r_pend;

    // Timing state
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DEAD_WIDTH-1:0] r_dcnt, w_dcnt_nx;
    logic                  r_raw_q, r_en_q;
    state_t                r_state, w_state_nx, w_side;

    // Registered outputs
    logic r_gate, r_gate_lo, r_period_start, r_cfg_err;

    logic w_last, w_xfer, w_per_ok, w_apply, w_raw;

    // Active period is always >= 2, so per_a-1 never underflows. Using >=
    // keeps the counter bounded even if it were ever outside the period.
    assign w_last   = (r_cnt >= (r_per_a - c_cnt_one));
    assign w_xfer   = cfg_valid && !r_pend;
    assign w_per_ok = (cfg_period >= c_min_period);
    // Apply at the wrap into 0, or at the end of the first enabled cycle
    // after en rises (the counter was parked at 0 while disabled).
    assign w_apply  = r_pend && en && (w_last || !r_en_q);
    assign w_raw    = en && (r_cnt < r_duty_a);
    assign w_side   = w_raw ? c_st_hi : c_st_lo;

    assign cfg_ready    = !r_pend;
    assign cfg_err      = r_cfg_err;
    assign gate         = r_gate;
    assign gate_lo      = r_gate_lo;
    assign period_start = r_period_start;

    // Configuration double buffer. Transfer needs !pend and apply needs
    // pend, so the two branches can never fire on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_per_a   <= c_def_period;
            r_duty_a  <= c_def_duty;
            r_dead_a  <= c_def_dead;
            r_per_p   <= c_def_period;
            r_duty_p  <= c_def_duty;
            r_dead_p  <= c_def_dead;
            r_pend    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_xfer && !w_per_ok;
            if (w_apply) begin
                r_per_a  <= r_per_p;
                r_duty_a <= r_duty_p;
                r_dead_a <= r_dead_p;
                r_pend   <= 1'b0;
            end else if (w_xfer && w_per_ok) begin
                r_per_p  <= cfg_period;
                r_duty_p <= cfg_duty;
                r_dead_p <= cfg_dead;
                r_pend   <= 1'b1;
            end
        end
    end

    // Period counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_en_q <= 1'b0;
        end else begin
            r_en_q <= en;
            if (!en || w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    // Dead-time FSM: next-state decides this cycle's drive. A raw edge (or
    // leaving OFF) opens a DEAD window of dead_a cycles; a zero dead time
    // skips DEAD entirely. dcnt holds the DEAD cycles still to go after
    // the current one.
    always_comb begin
        w_state_nx = r_state;
        w_dcnt_nx  = r_dcnt;
        if (!en) begin
            w_state_nx = c_st_off;
            w_dcnt_nx  = '0;
        end else if ((r_state == c_st_off) || (w_raw != r_raw_q)) begin
            if (r_dead_a == '0) begin
                w_state_nx = w_side;
            end else begin
                w_state_nx = c_st_dead;
                w_dcnt_nx  = r_dead_a - c_dead_one;
            end
        end else if (r_state == c_st_dead) begin
            if (r_dcnt == '0) begin
                w_state_nx = w_side;
            end else begin
                w_dcnt_nx = r_dcnt - c_dead_one;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= c_st_off;
            r_dcnt         <= '0;
            r_raw_q        <= 1'b0;
            r_gate         <= 1'b0;
            r_gate_lo      <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_dcnt         <= w_dcnt_nx;
            r_raw_q        <= w_raw;
            r_gate         <= (w_state_nx == c_st_hi);
            r_gate_lo      <= (w_state_nx == c_st_lo);
            r_period_start <= en && (r_cnt == '0);
        end
    end

    // Shoot-through protection: the two switches must never conduct together.
    a_gate_excl : assert property (@(posedge clk) disable iff (!rst)
                                   !(gate && gate_lo));

endmodule
`default_nettype wire

// File: tb/tb_pwm_gate_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pwm_gate_gen
// Purpose  : Self-checking bench for pwm_gate_gen. A small reference of the
//            counter and configuration buffer predicts period_start, cfg_err
//            and cfg_ready; gate levels in settled periods follow the
//            closed-form windows [D,duty) and [duty+D,per). Expectations are
//            queued before each edge and compared after it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_gate_gen;

    localparam int CW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, en, cfg_valid;
    logic [CW-1:0] cfg_period, cfg_duty;
    logic [DW-1:0] cfg_dead;
    logic          cfg_ready, cfg_err, gate, gate_lo, period_start;

    always #5 clk = ~clk;

    pwm_gate_gen #(
        .CNT_WIDTH (CW),
        .DEAD_WIDTH(DW),
        .DEF_PERIOD(200),
        .DEF_DUTY  (100),
        .DEF_DEAD  (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
        .cfg_dead    (cfg_dead),
        .cfg_err     (cfg_err),
        .gate        (gate),
        .gate_lo     (gate_lo),
        .period_start(period_start)
    );

    typedef struct {
        bit chk_g;
        bit g;
        bit lo;
        bit ps;
        bit err;
    } exp_t;

    typedef struct {
        int per;
        int duty;
        int dead;
        int hi;
        int lo;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state
    int m_cnt, m_per, m_duty, m_dead;
    int p_per, p_duty, p_dead;
    bit m_pend, m_en_q, m_ok, m_xfer;

    function automatic void check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endfunction

    function automatic bit f_hi(input int c, input int p, input int u, input int d);
        if (u == 0)  return 1'b0;
        if (u >= p)  return 1'b1;
        return (c >= d) && (c < u);
    endfunction

    function automatic bit f_lo(input int c, input int p, input int u, input int d);
        if (u == 0)  return 1'b1;
        if (u >= p)  return 1'b0;
        return (c >= u + d) && (c < p);
    endfunction

    function automatic void m_reset();
        m_cnt  = 0;
        m_per  = 200;
        m_duty = 100;
        m_dead = 0;
        p_per  = 0;
        p_duty = 0;
        p_dead = 0;
        m_pend = 1'b0;
        m_en_q = 1'b0;
        m_ok   = 1'b0;
        m_xfer = 1'b0;
    endfunction

    // One clock: predict, clock, update reference, compare.
    task automatic step();
        exp_t e;
        exp_t a;
        bit   last, apply;
        check("cfg_ready", int'(cfg_ready), int'(!m_pend));
        e.ps  = en && (m_cnt == 0);
        e.err = cfg_valid && !m_pend && (int'(cfg_period) < 2);
        if (!en) begin
            e.chk_g = 1'b1; e.g = 1'b0; e.lo = 1'b0;
        end else if (m_ok) begin
            e.chk_g = 1'b1;
            e.g     = f_hi(m_cnt, m_per, m_duty, m_dead);
            e.lo    = f_lo(m_cnt, m_per, m_duty, m_dead);
        end else begin
            e.chk_g = 1'b0; e.g = 1'b0; e.lo = 1'b0;
        end
        sb.push_back(e);

        @(posedge clk);
        last   = (m_cnt == m_per - 1);
        m_xfer = cfg_valid && !m_pend;
        apply  = m_pend && en && (last || !m_en_q);
        if (!en)        m_ok = 1'b0;
        else if (apply) m_ok = 1'b0;
        else if (last)  m_ok = 1'b1;
        if (apply) begin
            m_per  = p_per;
            m_duty = p_duty;
            m_dead = p_dead;
            m_pend = 1'b0;
        end else if (m_xfer && int'(cfg_period) >= 2) begin
            p_per  = int'(cfg_period);
            p_duty = int'(cfg_duty);
            p_dead = int'(cfg_dead);
            m_pend = 1'b1;
        end
        m_cnt  = (!en || last) ? 0 : m_cnt + 1;
        m_en_q = en;

        #1;
        a = sb.pop_front();
        check("period_start", int'(period_start), int'(a.ps));
        check("cfg_err", int'(cfg_err), int'(a.err));
        check("gate_excl", int'(gate && gate_lo), 0);
        if (a.chk_g) begin
            check($sformatf("gate cnt_prev=%0d", m_cnt), int'(gate), int'(a.g));
            check($sformatf("gate_lo cnt_prev=%0d", m_cnt), int'(gate_lo), int'(a.lo));
        end
    endtask

    task automatic send_cfg(input int p, input int u, input int d);
        int n = 0;
        cfg_valid  = 1'b1;
        cfg_period = CW'(p);
        cfg_duty   = CW'(u);
        cfg_dead   = DW'(d);
        do begin
            step();
            n++;
        end while (!m_xfer && n < 400);
        cfg_valid = 1'b0;
        if (!m_xfer) timeout("cfg_transfer");
    endtask

    task automatic wait_steady();
        int n = 0;
        while (!(m_ok && m_cnt == 0) && n < 600) begin
            step();
            n++;
        end
        if (!(m_ok && m_cnt == 0)) timeout("wait_steady");
    endtask

    task automatic step_to_cnt(input int c);
        int n = 0;
        while (m_cnt != c && n < 300) begin
            step();
            n++;
        end
        if (m_cnt != c) timeout($sformatf("step_to_cnt %0d", c));
    endtask

    // Steps from now until the next period_start output pulse.
    task automatic steps_to_ps(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!period_start && n < 400);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   hi, lo, n, errs, rdy_low, acc, psn;

        vecs[0] = '{per: 10, duty: 5,  dead: 0, hi: 5,  lo: 5};
        vecs[1] = '{per: 10, duty: 5,  dead: 2, hi: 3,  lo: 3};
        vecs[2] = '{per: 10, duty: 0,  dead: 0, hi: 0,  lo: 10};
        vecs[3] = '{per: 10, duty: 12, dead: 0, hi: 10, lo: 0};
        vecs[4] = '{per: 8,  duty: 3,  dead: 1, hi: 2,  lo: 4};
        vecs[5] = '{per: 12, duty: 6,  dead: 3, hi: 3,  lo: 3};

        rst        = 1'b0;
        en         = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_duty   = '0;
        cfg_dead   = '0;
        m_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_gate", int'(gate), 0);
        check("rst_gate_lo", int'(gate_lo), 0);
        check("rst_period_start", int'(period_start), 0);
        check("rst_cfg_err", int'(cfg_err), 0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        rst = 1'b1;
        en  = 1'b1;

        // Table: program each vector, let it settle, count one period.
        for (int i = 0; i < 6; i++) begin
            send_cfg(vecs[i].per, vecs[i].duty, vecs[i].dead);
            wait_steady();
            hi  = 0;
            lo  = 0;
            psn = 0;
            for (int k = 0; k < vecs[i].per; k++) begin
                step();
                hi  += int'(gate);
                lo  += int'(gate_lo);
                psn += int'(period_start);
            end
            check($sformatf("vec%0d hi_cycles", i), hi, vecs[i].hi);
            check($sformatf("vec%0d lo_cycles", i), lo, vecs[i].lo);
            check($sformatf("vec%0d ps_count", i), psn, 1);
        end

        // Back-to-back configuration around a wrap.
        send_cfg(10, 5, 0);
        wait_steady();
        step_to_cnt(3);
        cfg_valid  = 1'b1;
        cfg_period = CW'(20);
        cfg_duty   = CW'(15);
        cfg_dead   = DW'(0);
        step();
        cfg_period = CW'(10);
        cfg_duty   = CW'(5);
        cfg_dead   = DW'(2);
        rdy_low = 0;
        n       = 0;
        do begin
            if (!cfg_ready) rdy_low++;
            step();
            n++;
        end while (!m_xfer && n < 50);
        cfg_valid = 1'b0;
        check("b2b_ready_low_cycles", rdy_low, 6);
        steps_to_ps(n);
        check("b2b_new_period_len", n, 20);

        // Rejected configuration: period 1.
        wait_steady();
        cfg_valid  = 1'b1;
        cfg_period = CW'(1);
        cfg_duty   = CW'(3);
        cfg_dead   = DW'(0);
        step();
        cfg_valid = 1'b0;
        errs = int'(cfg_err);
        check("err_ready_after", int'(cfg_ready), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            errs += int'(cfg_err);
        end
        check("err_pulse_count", errs, 1);
        steps_to_ps(n);
        steps_to_ps(n);
        check("err_period_kept", n, 10);

        // Enable low: both gates off, no period pulses.
        en  = 1'b0;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            acc += int'(gate) + int'(gate_lo) + int'(period_start);
        end
        check("en_off_activity", acc, 0);
        en = 1'b1;

        // Reset mid-period with gate_lo high and a config pending.
        send_cfg(10, 5, 0);
        wait_steady();
        step_to_cnt(6);
        cfg_valid  = 1'b1;
        cfg_period = CW'(20);
        cfg_duty   = CW'(15);
        cfg_dead   = DW'(0);
        step();
        cfg_valid = 1'b0;
        check("pre_rst_gate_lo", int'(gate_lo), 1);
        check("pre_rst_ready", int'(cfg_ready), 0);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_gate", int'(gate), 0);
        check("async_rst_gate_lo", int'(gate_lo), 0);
        check("async_rst_period_start", int'(period_start), 0);
        check("async_rst_cfg_err", int'(cfg_err), 0);
        check("async_rst_ready", int'(cfg_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_reset();
        wait_steady();
        hi  = 0;
        lo  = 0;
        psn = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            hi  += int'(gate);
            lo  += int'(gate_lo);
            psn += int'(period_start);
        end
        check("def_hi_cycles", hi, 100);
        check("def_lo_cycles", lo, 100);
        check("def_ps_count", psn, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_gate_gen.md
# pwm_gate_gen

Counter-based PWM generator that produces the complementary gate drive for the buck power stage (`gate` into the buck model, `gate_lo` for a synchronous low-side switch). Period, duty and dead time are programmed through a valid/ready configuration port. New settings are double-buffered and take effect only at a period boundary, so no runt pulses occur. It sits directly upstream of the buck model in the testbench and replaces the fixed-duty `PWM` macro.

## Interface
- `CNT_WIDTH`, 16: width of the period counter, period and duty.
- `DEAD_WIDTH`, 8: width of the dead-time value.
- `DEF_PERIOD`, 200: period in clk cycles after reset (500 kHz at a 100 MHz clk).
- `DEF_DUTY`, 100: high-side on-count after reset.
- `DEF_DEAD`, 0: dead-time cycles after reset.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: run enable. When low, both gates are off and the counter is held.
- `cfg_valid` in 1: configuration offer.
- `cfg_ready` out 1: configuration slot free.
- `cfg_period` in CNT_WIDTH: requested period in cycles.
- `cfg_duty` in CNT_WIDTH: requested high-side count.
- `cfg_dead` in DEAD_WIDTH: requested dead time in cycles.
- `cfg_err` out 1: one-cycle pulse when an accepted config is rejected.
- `gate` out 1: high-side drive.
- `gate_lo` out 1: low-side drive.
- `period_start` out 1: one-cycle pulse marking counter value 0.

## Operation
- Registers:
  - Active set: `per_a`, `duty_a`, `dead_a`.
  - Pending set with flag `pend`.
  - Counter `cnt`, dead counter `dcnt`, previous raw level `raw_q`.
- Handshake:
  - `cfg_ready = !pend`.
  - A transfer occurs when `cfg_valid && cfg_ready` on a rising edge.
  - `cfg_valid` may drop without a transfer.
  - If `cfg_period < 2`: the transfer still completes, `cfg_err` pulses the next cycle, and `pend` stays 0 (the config is discarded).
  - Otherwise the values are stored and `pend` is set.
- Apply: the pending set is copied to the active set, and `pend` cleared, on the cycle `cnt` wraps to 0. This happens when `cnt == per_a-1` with `en` high, or on the first cycle after `en` rises. `cfg_ready` returns high the following cycle.
- Counter: counts 0 .. per_a-1 and wraps while `en` is high. When `en` is low, `cnt` is forced to 0.
- Raw level: `raw = en && (cnt < duty_a)`. A `duty_a >= per_a` value gives 100 % duty; `duty_a = 0` gives 0 %.
- Dead-time FSM, states OFF, DEAD, HI, LO:
  - OFF (en low): both gates low. When `en` rises, go to DEAD with `dcnt = dead_a`.
  - Any change of `raw` versus `raw_q`: enter DEAD and load `dcnt = dead_a`.
  - DEAD: both gates low. `dcnt` decrements. When `dcnt == 0`, go to HI if `raw`, else LO. With `dead_a = 0`, DEAD lasts zero cycles and the FSM goes straight to HI or LO.
  - HI: `gate` high. LO: `gate_lo` high.
  - `gate` and `gate_lo` are never high in the same cycle. This is a hard invariant to be asserted.
  - A raw pulse shorter than `dead_a` produces no output pulse on that side.
- `en` falling: FSM goes to OFF and both gates drop next cycle. Pending config is kept.
- Reset values:
  - `cnt = 0`, FSM = OFF, `pend = 0`.
  - Active set = DEF_* values.
  - Outputs: `gate = 0`, `gate_lo = 0`, `period_start = 0`, `cfg_err = 0`, `cfg_ready = 1`.
- Reset asserted mid-period: all state returns to the reset values immediately (asynchronously), and the pending config is lost.

## Timing
- `gate`, `gate_lo`, `period_start` and `cfg_err` are registered outputs. Each reflects the `cnt` and FSM state of the previous cycle, a fixed latency of 1 cycle.
- `period_start` is high exactly once per period, 1 cycle after the cycle in which `cnt == 0`.
- With a constant config and `dead_a = D`, `gate` is high for cycles corresponding to `cnt` in [D, duty_a). `gate_lo` is high for `cnt` in [duty_a+D, per_a), plus [0, D) spilling from the prior period only when duty is 0.
- A config accepted in cycle t while `cnt = c` takes effect at the next `cnt = 0`, i.e. `per_a-1-c` cycles later plus 1. This is visible on the outputs 1 cycle after that.
- `cfg_ready` low-to-high latency after apply: 1 cycle. A back-to-back transfer is possible on that cycle.

## Test plan
- Reset, `en=1`, config 10/5/0 → `gate` high for 5 of every 10 cycles, `gate_lo` high for the other 5, `period_start` every 10 cycles.
- Config 10/5/2 → per period: `gate` high 3 cycles (cnt 2–4), `gate_lo` high 3 cycles (cnt 7–9), both low 4 cycles. Never both high.
- Send config 20/15/0 at cnt=3, then offer a second config at once → `cfg_ready` low until the wrap. The new period starts at the next cnt=0. The second config is accepted on the following cycle.
- Duty 0 → `gate` constantly low. Duty 12 with period 10 → `gate` constantly high after the first DEAD window.
- `cfg_period = 1` → `cfg_err` pulses once, active settings unchanged, `cfg_ready` stays high.
- Assert `rst` low at cnt=7 with `gate_lo` high and a config pending → all outputs 0 at once. After release: DEF_* behaviour and `cfg_ready = 1`.
